// File: rtl/rc_osc_ctrl_pkg.sv
// Shared types and defaults for the 500 kHz RC oscillator enable sequencer / frequency monitor.
package rc_osc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STARTUP,
        ST_MEASURE,
        ST_EVAL,
        ST_RUN,
        ST_FAULT
    } state_e;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_SLOW = 2'b01;
    localparam logic [1:0] FC_FAST = 2'b10;

    localparam int DEF_STARTUP_CYC = 200;
    localparam int DEF_WIN_CYC     = 1000;
    localparam int DEF_CNT_W       = 16;
    localparam int DEF_MIN_CNT     = 40;
    localparam int DEF_MAX_CNT     = 60;

    // Interval timer width: enough to hold (longest interval - 1).
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rc_osc_edge_sync.sv
// Two-flop synchronizer for the free-running oscillator output followed by a
// registered rising-edge pulse (three wb_clk_i cycles from pin to pulse).
module rc_osc_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;
    logic rise_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            rise_q  <= sync2_q & ~prev_q;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/rc_osc_500k_ctrl.sv
// Enable sequencer and frequency monitor for the 500 kHz RC oscillator:
// start-up delay, edge counting over a fixed window, and continuous re-qualification.
//
// state   | meaning
// IDLE    | oscillator off, waiting for start
// STARTUP | osc_ena high, waiting for the oscillator to settle
// MEASURE | counting synchronized osc_dout rising edges
// EVAL    | meas_cnt/meas_vld presented, verdict taken
// RUN     | oscillator good; first cycle of the next monitoring window
// FAULT   | oscillator out of range, osc_ena low until restarted
module rc_osc_500k_ctrl
    import rc_osc_ctrl_pkg::*;
#(
    parameter int STARTUP_CYC = DEF_STARTUP_CYC,
    parameter int WIN_CYC     = DEF_WIN_CYC,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int MIN_CNT     = DEF_MIN_CNT,
    parameter int MAX_CNT     = DEF_MAX_CNT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             start,
    input  logic             stop,
    input  logic             osc_dout,
    output logic             osc_ena,
    output logic             busy,
    output logic             osc_ok,
    output logic             fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_vld
);

    localparam int TMR_W = tmr_width(STARTUP_CYC, WIN_CYC);
    localparam logic [TMR_W-1:0] STARTUP_LD = TMR_W'(STARTUP_CYC - 1);
    localparam logic [TMR_W-1:0] WIN_LD     = TMR_W'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_C      = CNT_W'(MIN_CNT);
    localparam logic [CNT_W-1:0] MAX_C      = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] CNT_SAT    = '1;

    state_e           state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0] meas_cnt_q, meas_cnt_d;
    logic             meas_vld_q, meas_vld_d;
    logic             osc_ok_q, osc_ok_d;
    logic [1:0]       fc_q, fc_d;
    logic             rise;
    logic             tmr_done;
    logic             in_range;

    rc_osc_edge_sync u_edge_sync (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .async_in (osc_dout),
        .rise     (rise)
    );

    assign tmr_done = (tmr_q == '0);
    assign in_range = (meas_cnt_q >= MIN_C) && (meas_cnt_q <= MAX_C);

    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        edge_cnt_d = edge_cnt_q;
        meas_cnt_d = meas_cnt_q;
        meas_vld_d = 1'b0;
        osc_ok_d   = osc_ok_q;
        fc_d       = fc_q;

        if (stop) begin
            state_d  = ST_IDLE;
            osc_ok_d = 1'b0;
            fc_d     = FC_NONE;
        end else begin
            case (state_q)
                ST_IDLE, ST_FAULT: begin
                    if (start) begin
                        state_d = ST_STARTUP;
                        tmr_d   = STARTUP_LD;
                        fc_d    = FC_NONE;
                    end
                end
                ST_STARTUP: begin
                    if (tmr_done) begin
                        state_d    = ST_MEASURE;
                        tmr_d      = WIN_LD;
                        edge_cnt_d = '0;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                // RUN occupies the first cycle of the following window so that
                // back-to-back windows repeat every WIN_CYC+1 cycles.
                ST_RUN, ST_MEASURE: begin
                    if (rise && (edge_cnt_q != CNT_SAT)) begin
                        edge_cnt_d = edge_cnt_q + 1'b1;
                    end
                    if (state_q == ST_RUN) begin
                        state_d = ST_MEASURE;
                        tmr_d   = tmr_q - 1'b1;
                    end else if (tmr_done) begin
                        state_d    = ST_EVAL;
                        meas_cnt_d = edge_cnt_d;
                        meas_vld_d = 1'b1;
                    end else begin
                        tmr_d = tmr_q - 1'b1;
                    end
                end
                ST_EVAL: begin
                    if (in_range) begin
                        state_d    = ST_RUN;
                        osc_ok_d   = 1'b1;
                        fc_d       = FC_NONE;
                        tmr_d      = WIN_LD;
                        edge_cnt_d = '0;
                    end else begin
                        state_d  = ST_FAULT;
                        osc_ok_d = 1'b0;
                        fc_d     = (meas_cnt_q < MIN_C) ? FC_SLOW : FC_FAST;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            tmr_q      <= '0;
            edge_cnt_q <= '0;
            meas_cnt_q <= '0;
            meas_vld_q <= 1'b0;
            osc_ok_q   <= 1'b0;
            fc_q       <= FC_NONE;
        end else begin
            state_q    <= state_d;
            tmr_q      <= tmr_d;
            edge_cnt_q <= edge_cnt_d;
            meas_cnt_q <= meas_cnt_d;
            meas_vld_q <= meas_vld_d;
            osc_ok_q   <= osc_ok_d;
            fc_q       <= fc_d;
        end
    end

    assign osc_ena    = (state_q == ST_STARTUP) || (state_q == ST_MEASURE) ||
                        (state_q == ST_EVAL)    || (state_q == ST_RUN);
    assign busy       = ((state_q == ST_STARTUP) || (state_q == ST_MEASURE) ||
                         (state_q == ST_EVAL)) && !osc_ok_q;
    assign osc_ok     = osc_ok_q;
    assign fault      = (state_q == ST_FAULT);
    assign fault_code = fc_q;
    assign meas_cnt   = meas_cnt_q;
    assign meas_vld   = meas_vld_q;

endmodule
